// File: rtl/pipe_mul_if.sv
// Issue/result bundle between the EX-stage issue logic and the pipelined multiplier.
interface pipe_mul_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic [1:0]       funct;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [TAG_W-1:0] rd_in;
    logic             out_valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] rd_out;

    modport master (
        output in_valid, funct, op_a, op_b, rd_in,
        input  out_valid, result, rd_out
    );

    modport slave (
        input  in_valid, funct, op_a, op_b, rd_in,
        output out_valid, result, rd_out
    );
endinterface

// File: rtl/pipe_mul_unit.sv
// Stall-aware pipelined multiplier (MUL/MULH/MULHSU/MULHU) with tag tracking,
// in-flight hazard query and final-stage forwarding outputs.
module pipe_mul_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [TAG_W-1:0] query_rs1,
    input  logic [TAG_W-1:0] query_rs2,
    output logic             hazard,
    output logic [CNT_W-1:0] occupancy,
    pipe_mul_if.slave        bus
);
    localparam logic [1:0] FN_MUL    = 2'b00;
    localparam logic [1:0] FN_MULH   = 2'b01;
    localparam logic [1:0] FN_MULHSU = 2'b10;
    localparam int         PW        = 2 * XLEN;
    localparam int         LAST      = STAGES - 1;

    logic             accept;
    logic             sign_a;
    logic             sign_b;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod_d;

    logic             valid_q [STAGES];
    logic [PW-1:0]    prod_q  [STAGES];
    logic [1:0]       fn_q    [STAGES];
    logic [TAG_W-1:0] rd_q    [STAGES];

    assign accept = bus.in_valid && !stall && !flush;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        unique case (bus.funct)
            FN_MULH: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            FN_MULHSU: sign_a = 1'b1;
            default: ;
        endcase
    end

    // Extending straight to 2*XLEN gives the same low bits as an
    // (XLEN+1)-bit signed multiply truncated to 2*XLEN.
    assign a_ext  = {{XLEN{sign_a & bus.op_a[XLEN-1]}}, bus.op_a};
    assign b_ext  = {{XLEN{sign_b & bus.op_b[XLEN-1]}}, bus.op_b};
    assign prod_d = $signed(a_ext) * $signed(b_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                prod_q[s]  <= '0;
                fn_q[s]    <= '0;
                rd_q[s]    <= '0;
            end
        end else if (!stall) begin
            valid_q[0] <= accept;
            prod_q[0]  <= prod_d;
            fn_q[0]    <= bus.funct;
            rd_q[0]    <= bus.rd_in;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                prod_q[s]  <= prod_q[s-1];
                fn_q[s]    <= fn_q[s-1];
                rd_q[s]    <= rd_q[s-1];
            end
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.rd_out    = rd_q[LAST];
    assign bus.result    = (fn_q[LAST] == FN_MUL)
                         ? prod_q[LAST][XLEN-1:0]
                         : prod_q[LAST][PW-1:XLEN];

    // Final stage is excluded: it is covered by forwarding.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < STAGES - 1; s++) begin
            if (valid_q[s] && rd_q[s] != '0 &&
                (rd_q[s] == query_rs1 || rd_q[s] == query_rs2))
                hazard = 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int s = 0; s < STAGES; s++)
            occupancy = occupancy + CNT_W'(valid_q[s]);
    end
endmodule

// File: tb/tb_pipe_mul_unit.sv
// Scoreboard bench for pipe_mul_unit: STAGES=2 instance checked by a monitor,
// STAGES=4 instance used for latency, fill, hazard and reset checks.
module tb_pipe_mul_unit;
    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       flush;
    logic [4:0] query_rs1;
    logic [4:0] query_rs2;
    logic       hazard2;
    logic       hazard4;
    logic [2:0] occ2;
    logic [2:0] occ4;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   occ_max = 0;
    bit   trk = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    pipe_mul_if #(.XLEN(32), .TAG_W(5)) m2 ();
    pipe_mul_if #(.XLEN(32), .TAG_W(5)) m4 ();

    pipe_mul_unit #(.XLEN(32), .STAGES(2), .TAG_W(5), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .hazard(hazard2), .occupancy(occ2), .bus(m2)
    );

    pipe_mul_unit #(.XLEN(32), .STAGES(4), .TAG_W(5), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .hazard(hazard4), .occupancy(occ4), .bus(m4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [1:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] ex, input int extra);
        m2.in_valid = 1'b1;
        m2.funct    = fn;
        m2.op_a     = a;
        m2.op_b     = b;
        m2.rd_in    = rd;
        q.push_back('{res: ex, rd: rd, due: cyc + 2 + extra});
    endtask

    task automatic issue2(input logic [1:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] ex, input int extra);
        send2(fn, a, b, rd, ex, extra);
        tick();
        m2.in_valid = 1'b0;
    endtask

    task automatic drive4(input logic [1:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        m4.in_valid = 1'b1;
        m4.funct    = fn;
        m4.op_a     = a;
        m4.op_b     = b;
        m4.rd_in    = rd;
    endtask

    // Monitor: an output is consumed on a cycle where the pipe advances.
    always @(negedge clk) begin
        if (m2.out_valid === 1'b1 && stall === 1'b0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: rd_out=%0d result=%h, expected none",
                         m2.rd_out, m2.result);
            end else begin
                mon_e = q.pop_front();
                chk("result", 64'(m2.result), 64'(mon_e.res));
                chk("rd_out", 64'(m2.rd_out), 64'(mon_e.rd));
                chk("latency_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
        if (trk && int'(occ2) > occ_max) occ_max = int'(occ2);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        query_rs1 = '0;
        query_rs2 = '0;
        m2.in_valid = 1'b0; m2.funct = '0; m2.op_a = '0;
        m2.op_b = '0; m2.rd_in = '0;
        m4.in_valid = 1'b0; m4.funct = '0; m4.op_a = '0;
        m4.op_b = '0; m4.rd_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(m2.out_valid), 64'd0);
        chk("rst_result", 64'(m2.result), 64'd0);
        chk("rst_rd_out", 64'(m2.rd_out), 64'd0);
        chk("rst_occupancy", 64'(occ2), 64'd0);
        chk("rst_hazard", 64'(hazard2), 64'd0);
        tick();

        // Basic MUL, hazard while in stage 0 only
        issue2(MUL, 32'd7, 32'd6, 5'd5, 32'd42, 0);
        query_rs1 = 5'd5;
        @(negedge clk);
        chk("hazard_stage0", 64'(hazard2), 64'd1);
        chk("occ_inflight", 64'(occ2), 64'd1);
        tick();
        @(negedge clk);
        chk("hazard_final_excluded", 64'(hazard2), 64'd0);
        query_rs1 = '0;
        tick();

        // Signedness vectors, back to back
        send2(MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0);
        tick();
        send2(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, 0);
        tick();
        send2(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 0);
        tick();
        send2(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, 0);
        tick();
        send2(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 0);
        tick();
        send2(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 0);
        tick();
        m2.in_valid = 1'b0;
        repeat (3) tick();

        // Throughput: four consecutive ops, occupancy peaks at STAGES
        occ_max = 0;
        trk = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send2(MUL, 32'(i * 10), 32'(i), 5'(i), 32'(i * i * 10), 0);
            tick();
        end
        m2.in_valid = 1'b0;
        repeat (3) tick();
        trk = 1'b0;
        chk("occ_peak", 64'(occ_max), 64'd2);

        // Stall while op sits in stage 0
        issue2(MUL, 32'd3, 32'd5, 5'd3, 32'd15, 3);
        stall = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_out_valid", 64'(m2.out_valid), 64'd0);
        chk("stall_occ", 64'(occ2), 64'd1);
        tick();
        tick();
        stall = 1'b0;
        repeat (4) tick();

        // Stall while op sits in the final stage: held, counted once
        issue2(MUL, 32'd100, 32'd3, 5'd11, 32'd300, 2);
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("held_out_valid", 64'(m2.out_valid), 64'd1);
        chk("held_result", 64'(m2.result), 64'd300);
        tick();
        @(negedge clk);
        chk("held_rd_out", 64'(m2.rd_out), 64'd11);
        tick();
        stall = 1'b0;
        repeat (3) tick();

        // stall + flush together: nothing accepted
        m2.in_valid = 1'b1; m2.funct = MUL; m2.op_a = 32'd9;
        m2.op_b = 32'd9; m2.rd_in = 5'd20;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        m2.in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("stall_flush_occ", 64'(occ2), 64'd0);
        repeat (3) tick();

        // Flush kills the presented op, in-flight op completes
        issue2(MULHU, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h0000_0001, 0);
        m2.in_valid = 1'b1; m2.funct = MUL; m2.op_a = 32'd2;
        m2.op_b = 32'd2; m2.rd_in = 5'd13;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_occ_before", 64'(occ2), 64'd1);
        tick();
        m2.in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_occ_after", 64'(occ2), 64'd1);
        repeat (4) tick();

        // STAGES=4: latency and hazard through non-final stages
        drive4(MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9);
        tick();
        m4.in_valid = 1'b0;
        query_rs1 = 5'd9;
        tick();
        tick();
        @(negedge clk);
        chk("s4_early_valid", 64'(m4.out_valid), 64'd0);
        chk("s4_hazard_stage2", 64'(hazard4), 64'd1);
        tick();
        @(negedge clk);
        chk("s4_out_valid", 64'(m4.out_valid), 64'd1);
        chk("s4_result", 64'(m4.result), 64'd1);
        chk("s4_rd_out", 64'(m4.rd_out), 64'd9);
        chk("s4_hazard_final", 64'(hazard4), 64'd0);
        query_rs1 = '0;
        tick();
        tick();

        // Fill STAGES=4 pipe, probe hazards, then reset
        drive4(MUL, 32'd6, 32'd2, 5'd5);
        tick();
        drive4(MUL, 32'd7, 32'd2, 5'd6);
        tick();
        drive4(MUL, 32'd8, 32'd2, 5'd7);
        tick();
        drive4(MUL, 32'd1, 32'd2, 5'd0);
        tick();
        m4.in_valid = 1'b0;
        @(negedge clk);
        chk("s4_full_occ", 64'(occ4), 64'd4);
        chk("s4_full_rd_out", 64'(m4.rd_out), 64'd5);
        chk("s4_full_result", 64'(m4.result), 64'd12);
        chk("s4_rd0_no_hazard", 64'(hazard4), 64'd0);
        query_rs1 = 5'd5;
        #1;
        chk("s4_final_no_hazard", 64'(hazard4), 64'd0);
        query_rs2 = 5'd6;
        #1;
        chk("s4_stage2_hazard", 64'(hazard4), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("s4_rst_out_valid", 64'(m4.out_valid), 64'd0);
        chk("s4_rst_occ", 64'(occ4), 64'd0);
        chk("s4_rst_hazard", 64'(hazard4), 64'd0);
        chk("s4_rst_result", 64'(m4.result), 64'd0);
        chk("s4_rst_rd_out", 64'(m4.rd_out), 64'd0);
        query_rs1 = '0;
        query_rs2 = '0;
        repeat (6) tick();

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
